seven_seg_multi_display: RTL and testbench

Parametrised multi-digit decimal display driver for the game's seven-segment bank. It takes a binary count from the game logic and converts it to BCD with a sequential double-dabble engine, one shift per clock. Each digit is decoded to its own 7-segment field. It adds leading-zero blanking, an overflow indication and a blink mode for the "time almost out" warning.

---
 rtl/seven_seg_multi_display.sv | 181 ++++++++++++++++++
 tb/tb_seven_seg_multi_display.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_multi_display.sv
// rtl/seven_seg_multi_display.sv - binary to multi-digit seven-segment driver
// Sequential double-dabble conversion, leading-zero blanking, overflow dashes and blink.
module seven_seg_multi_display #(
  parameter int WIDTH      = 8,
  parameter int NUM_DIGITS = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          value,
  input  logic                      load,
  input  logic                      blank_lz,
  input  logic                      blink_en,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [7*NUM_DIGITS-1:0]   segments
);

  function automatic int bcd_digits(input int w);
    longint m;
    int     d;
    m = (longint'(1) << w) - 1;
    d = 0;
    do begin
      d++;
      m = m / 10;
    end while (m != 0);
    return d;
  endfunction

  localparam int BCD_NEED   = bcd_digits(WIDTH);
  localparam int ACC_DIGITS = (BCD_NEED > NUM_DIGITS) ? BCD_NEED : NUM_DIGITS;
  localparam int ACC_W      = 4 * ACC_DIGITS;
  localparam int STEP_W     = $clog2(WIDTH + 1);
  localparam int BLINK_W    = $clog2(BLINK_DIV + 1);
  localparam logic [7*NUM_DIGITS-1:0] SEG_OFF = {(7*NUM_DIGITS){ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_LATCH} state_t;

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          shift_q, shift_d;
  logic [ACC_W-1:0]          bcd_q, bcd_d, bcd_adj;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [4*NUM_DIGITS-1:0]   disp_q, disp_d;
  logic                      ovf_q, ovf_d;
  logic                      done_q, done_d;
  logic [BLINK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                      hidden_q, hidden_d;
  logic [7*NUM_DIGITS-1:0]   seg_q, seg_d;
  logic                      high_nz;
  logic                      leading;
  logic                      hide_now;
  logic [3:0]                digit;
  logic [6:0]                lit;

  // Lit pattern with 1 = segment on, bit 0 = a.
  function automatic logic [6:0] seg_lit(input logic [3:0] d);
    case (d)
      4'd0:    seg_lit = 7'h3F;
      4'd1:    seg_lit = 7'h06;
      4'd2:    seg_lit = 7'h5B;
      4'd3:    seg_lit = 7'h4F;
      4'd4:    seg_lit = 7'h66;
      4'd5:    seg_lit = 7'h6D;
      4'd6:    seg_lit = 7'h7D;
      4'd7:    seg_lit = 7'h07;
      4'd8:    seg_lit = 7'h7F;
      4'd9:    seg_lit = 7'h6F;
      default: seg_lit = 7'h00;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    high_nz = 1'b0;
    for (int i = NUM_DIGITS; i < ACC_DIGITS; i++) begin
      high_nz = high_nz | (bcd_q[4*i +: 4] != 4'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d = value;
          bcd_d   = '0;
          step_d  = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_d   = ACC_W'({bcd_adj, shift_q[WIDTH-1]});
        shift_d = shift_q << 1;
        step_d  = step_q + STEP_W'(1);
        if (step_q == STEP_W'(WIDTH - 1)) state_d = S_LATCH;
      end
      S_LATCH: begin
        disp_d  = bcd_q[4*NUM_DIGITS-1:0];
        ovf_d   = high_nz;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    hidden_d    = hidden_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      hidden_d    = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      hidden_d    = ~hidden_q;
    end
  end

  // Dropping blink_en unhides on the very next registered output.
  assign hide_now = blink_en & hidden_q;

  always_comb begin
    seg_d   = '0;
    leading = 1'b1;
    digit   = '0;
    lit     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digit   = disp_q[4*i +: 4];
      leading = leading & (digit == 4'd0);
      if (hide_now)                          lit = 7'h00;
      else if (ovf_q)                        lit = 7'h40;
      else if (blank_lz && leading && i != 0) lit = 7'h00;
      else                                   lit = seg_lit(digit);
      seg_d[7*i +: 7] = (ACTIVE_LOW != 0) ? ~lit : lit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      step_q      <= '0;
      disp_q      <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
      seg_q       <= SEG_OFF;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      step_q      <= step_d;
      disp_q      <= disp_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
      seg_q       <= seg_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign segments = seg_q;

endmodule

// File: tb/tb_seven_seg_multi_display.sv
// tb/tb_seven_seg_multi_display.sv - self-checking bench for seven_seg_multi_display
// Two instances: 3 digits active-low and 2 digits active-high, both 8-bit input.
module tb_seven_seg_multi_display;

  localparam int WIDTH = 8;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100;
  localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010, D7 = 7'b1111000;
  localparam logic [6:0] D9 = 7'b0010000, OFF = 7'b1111111, DASH = 7'b0111111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] value = '0;
  logic             load = 1'b0, blank_lz = 1'b0, blink_en = 1'b0;
  logic             busy1, done1, ovf1, busy2, done2, ovf2;
  logic [20:0]      seg1;
  logic [13:0]      seg2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seven_seg_multi_display #(.WIDTH(WIDTH), .NUM_DIGITS(3), .ACTIVE_LOW(1), .BLINK_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz), .blink_en(blink_en),
    .busy(busy1), .done(done1), .overflow(ovf1), .segments(seg1));

  seven_seg_multi_display #(.WIDTH(WIDTH), .NUM_DIGITS(2), .ACTIVE_LOW(0), .BLINK_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz), .blink_en(blink_en),
    .busy(busy2), .done(done2), .overflow(ovf2), .segments(seg2));

  typedef struct {
    int          v;
    bit          blz;
    logic [20:0] exp_seg3;
    logic        exp_ovf2;
  } vec_t;

  function automatic logic [6:0] lo_code(input int d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected segment vector computed from decimal arithmetic on the value.
  function automatic logic [63:0] model(input int v, input int nd, input bit blz,
                                        input bit hid, input bit alow);
    logic [63:0] r;
    logic [6:0]  c;
    longint      p, lim;
    r = '0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      if (hid)                       c = OFF;
      else if (v >= lim)             c = DASH;
      else if (blz && i > 0 && v < p) c = OFF;
      else                           c = lo_code(int'((v / p) % 10));
      if (!alow) c = ~c;
      r[7*i +: 7] = c;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load v, optionally re-pulse load at loop index extra_at (must be ignored).
  task automatic convert(input int v, input bit blz, input int extra_at, input int extra_v);
    int b1, b2, d1n, d2n, d_edge;
    value = v[WIDTH-1:0];
    blank_lz = blz;
    load = 1'b1;
    b1 = 0; b2 = 0; d1n = 0; d2n = 0; d_edge = -1;
    for (int c = 0; c <= WIDTH + 2; c++) begin
      tick();
      if (busy1) b1++;
      if (busy2) b2++;
      if (done1) begin d1n++; d_edge = c; end
      if (done2) d2n++;
      if (c == extra_at) begin
        load = 1'b1;
        value = extra_v[WIDTH-1:0];
      end else begin
        load = 1'b0;
      end
    end
    check("busy_cycles", b1, WIDTH + 1);
    check("busy_cycles2", b2, WIDTH + 1);
    check("done_count", d1n, 1);
    check("done_count2", d2n, 1);
    check("done_edge", d_edge, WIDTH + 1);
    check("seg3", seg1, model(v, 3, blz, 1'b0, 1'b1));
    check("seg2", seg2, model(v, 2, blz, 1'b0, 1'b0));
    check("ovf3", ovf1, v >= 1000);
    check("ovf2", ovf2, v >= 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int   n;
    int   v;
    tbl[0] = '{127, 1'b0, {D1, D2, D7}, 1'b1};
    tbl[1] = '{5,   1'b1, {OFF, OFF, D5}, 1'b0};
    tbl[2] = '{0,   1'b1, {OFF, OFF, D0}, 1'b0};
    tbl[3] = '{0,   1'b0, {D0, D0, D0}, 1'b0};
    tbl[4] = '{42,  1'b0, {D0, D4, D2}, 1'b0};
    tbl[5] = '{255, 1'b0, {D2, D5, D5}, 1'b1};
    tbl[6] = '{10,  1'b1, {OFF, D1, D0}, 1'b0};
    tbl[7] = '{100, 1'b1, {D1, D0, D0}, 1'b1};
    tbl[8] = '{99,  1'b0, {D0, D9, D9}, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_ovf", ovf1, 1'b0);
    check("rst_seg3", seg1, 21'h1FFFFF);
    check("rst_seg2", seg2, 14'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("init_seg3", seg1, {D0, D0, D0});
    check("init_seg2", seg2, model(0, 2, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 9; i++) begin
      convert(tbl[i].v, tbl[i].blz, -1, 0);
      check("tbl_seg3", seg1, tbl[i].exp_seg3);
      check("tbl_ovf2", ovf2, tbl[i].exp_ovf2);
    end

    // Second load during conversion is dropped.
    convert(42, 1'b0, 2, 200);
    check("ignored_load_seg3", seg1, {D0, D4, D2});

    // Load in the done cycle starts a new conversion immediately.
    value = 8'd7; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (!done1 && n < 20) begin tick(); n++; end
    check("b2b_done1", done1, 1'b1);
    value = 8'd9; load = 1'b1;
    tick();
    load = 1'b0;
    check("b2b_accept", busy1, 1'b1);
    n = 0;
    while (!done1 && n < 20) begin tick(); n++; end
    check("b2b_done2", done1, 1'b1);
    tick();
    check("b2b_seg3", seg1, model(9, 3, 1'b0, 1'b0, 1'b1));

    // Blink: visible 4 cycles, hidden 4 cycles, then release while hidden.
    convert(42, 1'b0, -1, 0);
    blink_en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check("blink_seg3", seg1, model(42, 3, 1'b0, ((k - 1) / 4) % 2 == 1, 1'b1));
      check("blink_seg2", seg2, model(42, 2, 1'b0, ((k - 1) / 4) % 2 == 1, 1'b0));
    end
    blink_en = 1'b0;
    tick();
    check("unblink_seg3", seg1, model(42, 3, 1'b0, 1'b0, 1'b1));

    // Live blank_lz toggle on a held display.
    blank_lz = 1'b1;
    tick();
    check("live_blank_seg3", seg1, {OFF, D4, D2});

    // Reset at conversion step 4 aborts with no done.
    blank_lz = 1'b0;
    value = 8'd200; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy1, 1'b0);
    check("abort_seg3", seg1, 21'h1FFFFF);
    check("abort_seg2", seg2, 14'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("abort_zero_seg3", seg1, {D0, D0, D0});
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done1) n++;
    end
    check("abort_no_done", n, 0);

    for (int i = 0; i < 16; i++) begin
      v = int'($urandom_range(0, 255));
      convert(v, $urandom_range(0, 1) == 1, (i % 2 == 1) ? int'($urandom_range(0, WIDTH)) : -1,
              int'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
